// File: rtl/stage_m_mem.sv
// M pipeline stage: E/M register, byte-addressable data memory with sub-word
// stores and loads, misalignment detection and write-back data selection.
`timescale 1ns/1ps
module stage_m_mem #(
  parameter int unsigned DM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] C_E,
  input  logic [31:0] RD2_new,
  input  logic [31:0] PC_E,
  input  logic [4:0]  A3_E,
  input  logic [1:0]  RFWDSel_E,
  input  logic [2:0]  MemOp_E,
  input  logic [31:0] RFWD_W,
  input  logic        MF_DMWD_Sel,
  output logic [31:0] RFWD_M,
  output logic [31:0] WD_M,
  output logic [4:0]  A3_M,
  output logic [31:0] PC_M,
  output logic        AdE_M
);

  localparam int unsigned AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_SW   = 3'b001,
    OP_SH   = 3'b010,
    OP_SB   = 3'b011,
    OP_LW   = 3'b100,
    OP_LH   = 3'b101,
    OP_LB   = 3'b110,
    OP_LBU  = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC8 = 2'b10,
    WB_RSV = 2'b11
  } wb_sel_e;

  logic [31:0] c_q;
  logic [31:0] d_q;
  logic [31:0] pc_q;
  logic [4:0]  a3_q;
  wb_sel_e     sel_q;
  mem_op_e     op_q;

  logic [31:0] mem [DM_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   ds;
  logic [31:0]   rd_word;
  logic [15:0]   rd_half;
  logic [7:0]    rd_byte;
  logic          ade;
  logic          is_store;
  logic          wr_en;
  logic [31:0]   wr_mask;
  logic [31:0]   wr_data;
  logic [31:0]   ld_data;
  logic [31:0]   rfwd;
  logic          unused_c_hi;

  // E/M register: flush beats stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q   <= '0;
      d_q   <= '0;
      pc_q  <= '0;
      a3_q  <= '0;
      sel_q <= WB_ALU;
      op_q  <= OP_NONE;
    end else if (flush) begin
      c_q   <= '0;
      d_q   <= '0;
      pc_q  <= '0;
      a3_q  <= '0;
      sel_q <= WB_ALU;
      op_q  <= OP_NONE;
    end else if (en) begin
      c_q   <= C_E;
      d_q   <= RD2_new;
      pc_q  <= PC_E;
      a3_q  <= A3_E;
      sel_q <= wb_sel_e'(RFWDSel_E);
      op_q  <= mem_op_e'(MemOp_E);
    end
  end

  assign idx         = c_q[AW+1:2];
  assign ds          = MF_DMWD_Sel ? RFWD_W : d_q;
  assign rd_word     = mem[idx];
  assign unused_c_hi = ^c_q[31:AW+2];

  always_comb begin
    ade = 1'b0;
    case (op_q)
      OP_SW, OP_LW: ade = |c_q[1:0];
      OP_SH, OP_LH: ade = c_q[0];
      default:      ade = 1'b0;
    endcase
  end

  // Sub-word stores become a masked read-modify-write of the addressed word
  always_comb begin
    wr_mask  = '0;
    wr_data  = '0;
    is_store = 1'b0;
    case (op_q)
      OP_SW: begin
        is_store = 1'b1;
        wr_mask  = '1;
        wr_data  = ds;
      end
      OP_SH: begin
        is_store = 1'b1;
        wr_mask  = c_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wr_data  = {2{ds[15:0]}};
      end
      OP_SB: begin
        is_store = 1'b1;
        wr_mask  = 32'h0000_00FF << {c_q[1:0], 3'b000};
        wr_data  = {4{ds[7:0]}};
      end
      default: begin
        is_store = 1'b0;
      end
    endcase
    wr_en = is_store && !ade;
  end

  // A stalled store rewrites the same data every edge, so en is not consulted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= (mem[idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign rd_half = c_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (c_q[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    ld_data = rd_word;
    case (op_q)
      OP_LH:   ld_data = {{16{rd_half[15]}}, rd_half};
      OP_LB:   ld_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  ld_data = {24'h0, rd_byte};
      default: ld_data = rd_word;
    endcase
    if (ade) begin
      ld_data = '0;
    end
  end

  assign rfwd   = (sel_q == WB_PC8) ? pc_q + 32'd8 : c_q;
  assign RFWD_M = rfwd;
  assign WD_M   = (sel_q == WB_MEM) ? ld_data : rfwd;
  assign A3_M   = a3_q;
  assign PC_M   = pc_q;
  assign AdE_M  = ade;

endmodule
